// File: rtl/isram_fetch_align_pkg.sv
// Shared fetch-side types: line-buffer entry, fill-state encoding and halfword select.
package isram_fetch_align_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [28:0] tag;
        logic [63:0] data;
    } line_entry_t;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_TWO   = 2'd2
    } fill_state_t;

    function automatic logic [15:0] hw_sel(input logic [63:0] line, input logic [1:0] idx);
        logic [15:0] hw;
        case (idx)
            2'd0:    hw = line[15:0];
            2'd1:    hw = line[31:16];
            2'd2:    hw = line[47:32];
            default: hw = line[63:48];
        endcase
        return hw;
    endfunction

endpackage

// File: rtl/isram_fetch_align_if.sv
// Fetch-side bundle: PC and SRAM read port in, aligned instruction and status out.
interface isram_fetch_align_if;
    logic [31:0] pc;
    logic        isram_cs;
    logic [28:0] isram_adr;
    logic [63:0] isram_rdata;
    logic        jb_ff;
    logic [31:0] rv32_instr;
    logic        isrv16;
    logic        fetch_misalign;
    logic        instr_valid;

    modport master (
        output pc, isram_cs, isram_adr, isram_rdata, jb_ff,
        input  rv32_instr, isrv16, fetch_misalign, instr_valid
    );

    modport slave (
        input  pc, isram_cs, isram_adr, isram_rdata, jb_ff,
        output rv32_instr, isrv16, fetch_misalign, instr_valid
    );
endinterface

// File: rtl/fetch_line_buf.sv
// Two-entry instruction line buffer with write-select and dual tag lookup (line, line+1).
//   state      | meaning
//   FILL_EMPTY | no valid entries
//   FILL_ONE   | one valid entry
//   FILL_TWO   | both entries valid
module fetch_line_buf
    import isram_fetch_align_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [28:0] wr_tag,
    input  logic [63:0] wr_data,
    input  logic        flush,
    input  logic [28:0] lo_tag,
    input  logic [28:0] hi_tag,
    output logic        lo_hit,
    output logic [63:0] lo_data,
    output logic        hi_hit,
    output logic [63:0] hi_data
);
    line_entry_t ent_q [2];
    logic        wr_sel;
    logic        new_tag;
    fill_state_t fill_q, fill_d;

    // Refresh a matching line first; never evict the line the PC is sitting on.
    always_comb begin
        new_tag = 1'b1;
        wr_sel  = 1'b1;
        if (ent_q[0].valid && ent_q[0].tag == wr_tag) begin
            wr_sel  = 1'b0;
            new_tag = 1'b0;
        end else if (ent_q[1].valid && ent_q[1].tag == wr_tag) begin
            wr_sel  = 1'b1;
            new_tag = 1'b0;
        end else if (!ent_q[0].valid) begin
            wr_sel = 1'b0;
        end else if (!ent_q[1].valid) begin
            wr_sel = 1'b1;
        end else if (ent_q[0].tag != lo_tag) begin
            wr_sel = 1'b0;
        end
    end

    always_comb begin
        lo_hit  = 1'b0;
        lo_data = '0;
        hi_hit  = 1'b0;
        hi_data = '0;
        for (int i = 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].tag == lo_tag) begin
                lo_hit  = 1'b1;
                lo_data = ent_q[i].data;
            end
            if (ent_q[i].valid && ent_q[i].tag == hi_tag) begin
                hi_hit  = 1'b1;
                hi_data = ent_q[i].data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else if (flush) begin
            ent_q[1].valid <= 1'b0;
            if (wr_en) ent_q[0] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
            else       ent_q[0].valid <= 1'b0;
        end else if (wr_en) begin
            ent_q[wr_sel] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fill_q <= FILL_EMPTY;
        else     fill_q <= fill_d;
    end

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = wr_en ? FILL_ONE : FILL_EMPTY;
        end else if (wr_en) begin
            case (fill_q)
                FILL_EMPTY: fill_d = FILL_ONE;
                FILL_ONE:   if (new_tag) fill_d = FILL_TWO;
                default:    fill_d = fill_q;
            endcase
        end
    end

    fill_matches_valid: assert property (@(posedge clk) disable iff (rst)
        fill_q == fill_state_t'({1'b0, ent_q[0].valid} + {1'b0, ent_q[1].valid}));

endmodule

// File: rtl/isram_fetch_align.sv
// Captures SRAM lines one cycle after isram_cs and extracts the 16/32-bit instruction at pc,
// including 32-bit instructions straddling two lines.
module isram_fetch_align
    import isram_fetch_align_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
)
(
    input  logic                clk,
    input  logic                cpurst,
    isram_fetch_align_if.slave  bus
);
    logic        req_q;
    logic [28:0] req_adr_q;
    logic [28:0] lo_tag, hi_tag;
    logic [1:0]  pc_hw;
    logic        buf_lo_hit, buf_hi_hit;
    logic [63:0] buf_lo_data, buf_hi_data;
    logic        byp_lo, byp_hi, lo_ok, hi_ok;
    logic [63:0] lo_line, hi_line;
    logic [15:0] lo_hw, hi_hw;
    logic [31:0] instr;
    logic        rv16, misalign;
    logic        unused_pc0;

    assign unused_pc0 = bus.pc[0];
    assign lo_tag     = bus.pc[31:3];
    assign hi_tag     = lo_tag + 29'd1;
    assign pc_hw      = bus.pc[2:1];

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            req_q     <= 1'b0;
            req_adr_q <= '0;
        end else begin
            req_q <= bus.isram_cs;
            if (bus.isram_cs) req_adr_q <= bus.isram_adr;
        end
    end

    fetch_line_buf u_line_buf (
        .clk     (clk),
        .rst     (cpurst),
        .wr_en   (req_q),
        .wr_tag  (req_adr_q),
        .wr_data (bus.isram_rdata),
        .flush   (bus.jb_ff),
        .lo_tag  (lo_tag),
        .hi_tag  (hi_tag),
        .lo_hit  (buf_lo_hit),
        .lo_data (buf_lo_data),
        .hi_hit  (buf_hi_hit),
        .hi_data (buf_hi_data)
    );

    // The in-flight response overrides the buffer so the line is usable in its arrival cycle.
    always_comb begin
        byp_lo   = req_q && (req_adr_q == lo_tag);
        byp_hi   = req_q && (req_adr_q == hi_tag);
        lo_ok    = byp_lo | buf_lo_hit;
        lo_line  = byp_lo ? bus.isram_rdata : buf_lo_data;
        hi_line  = byp_hi ? bus.isram_rdata : buf_hi_data;
        lo_hw    = hw_sel(lo_line, pc_hw);
        hi_ok    = lo_ok;
        hi_hw    = hw_sel(lo_line, pc_hw + 2'd1);
        if (pc_hw == 2'b11) begin
            hi_ok = byp_hi | buf_hi_hit;
            hi_hw = hi_line[15:0];
        end

        instr    = NOP_INSTR;
        rv16     = 1'b0;
        misalign = 1'b1;
        if (lo_ok && lo_hw[1:0] != 2'b11) begin
            instr    = {16'h0000, lo_hw};
            rv16     = 1'b1;
            misalign = 1'b0;
        end else if (lo_ok && hi_ok) begin
            instr    = {hi_hw, lo_hw};
            misalign = 1'b0;
        end
    end

    assign bus.rv32_instr     = instr;
    assign bus.isrv16         = rv16;
    assign bus.fetch_misalign = misalign;
    assign bus.instr_valid    = !misalign;

endmodule

// File: tb/tb_isram_fetch_align.sv
// Directed bench for isram_fetch_align with a line-level reference model checked every cycle.
module tb_isram_fetch_align;
    logic clk = 1'b0;
    logic cpurst = 1'b1;
    always #5 clk = ~clk;

    isram_fetch_align_if bus();

    isram_fetch_align #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk    (clk),
        .cpurst (cpurst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: set of cached lines plus the response currently on the bus.
    logic        m_req;
    logic [28:0] m_adr;
    logic        m_v   [2];
    logic [28:0] m_tag [2];
    logic [63:0] m_dat [2];
    int          m_slot;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void find_line(input logic [28:0] tag, output logic ok, output logic [63:0] line);
        ok   = 1'b0;
        line = '0;
        if (m_req && m_adr == tag) begin
            ok   = 1'b1;
            line = bus.isram_rdata;
        end else begin
            for (int i = 0; i < 2; i++)
                if (!ok && m_v[i] && m_tag[i] == tag) begin
                    ok   = 1'b1;
                    line = m_dat[i];
                end
        end
    endfunction

    function automatic void model_out(output logic [31:0] ins, output logic rv16, output logic mis);
        logic        ok_lo, ok_hi;
        logic [63:0] l_lo, l_hi;
        logic [15:0] lo, hi;
        int          k;
        k = int'(bus.pc[2:1]);
        find_line(bus.pc[31:3], ok_lo, l_lo);
        lo = l_lo[16*k +: 16];
        if (k < 3) begin
            ok_hi = ok_lo;
            hi    = l_lo[16*(k+1) +: 16];
        end else begin
            find_line(bus.pc[31:3] + 29'd1, ok_hi, l_hi);
            hi = l_hi[15:0];
        end
        ins  = 32'h0000_0013;
        rv16 = 1'b0;
        mis  = 1'b1;
        if (ok_lo && lo[1:0] != 2'b11) begin
            ins  = {16'h0000, lo};
            rv16 = 1'b1;
            mis  = 1'b0;
        end else if (ok_lo && ok_hi) begin
            ins = {hi, lo};
            mis = 1'b0;
        end
    endfunction

    always @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            m_req = 1'b0;
            m_adr = '0;
            for (int i = 0; i < 2; i++) begin
                m_v[i]   = 1'b0;
                m_tag[i] = '0;
                m_dat[i] = '0;
            end
        end else begin
            if (bus.jb_ff) begin
                m_v[1] = 1'b0;
                m_v[0] = m_req;
                if (m_req) begin
                    m_tag[0] = m_adr;
                    m_dat[0] = bus.isram_rdata;
                end
            end else if (m_req) begin
                m_slot = -1;
                for (int i = 0; i < 2; i++) if (m_slot < 0 && m_v[i] && m_tag[i] == m_adr) m_slot = i;
                for (int i = 0; i < 2; i++) if (m_slot < 0 && !m_v[i]) m_slot = i;
                for (int i = 0; i < 2; i++) if (m_slot < 0 && m_tag[i] != bus.pc[31:3]) m_slot = i;
                if (m_slot < 0) m_slot = 1;
                m_v[m_slot]   = 1'b1;
                m_tag[m_slot] = m_adr;
                m_dat[m_slot] = bus.isram_rdata;
            end
            m_req = bus.isram_cs;
            if (bus.isram_cs) m_adr = bus.isram_adr;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_ins;
        logic        e16, emis;
        model_out(e_ins, e16, emis);
        check("cmp_misalign", 32'(bus.fetch_misalign), 32'(emis));
        check("cmp_valid",    32'(bus.instr_valid),    32'(!emis));
        check("cmp_isrv16",   32'(bus.isrv16),         32'(e16));
        if (e16) check("cmp_instr16", {16'h0000, bus.rv32_instr[15:0]}, e_ins);
        else     check("cmp_instr",   bus.rv32_instr, e_ins);
    end

    task automatic apply(input logic rst, input logic [31:0] pc, input logic cs,
                         input logic [28:0] adr, input logic [63:0] rdata, input logic jb);
        @(posedge clk);
        #1;
        cpurst          = rst;
        bus.pc          = pc;
        bus.isram_cs    = cs;
        bus.isram_adr   = adr;
        bus.isram_rdata = rdata;
        bus.jb_ff       = jb;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic mis, input logic rv16, input logic [31:0] instr);
        check({name, "_mis"},   32'(bus.fetch_misalign), 32'(mis));
        check({name, "_valid"}, 32'(bus.instr_valid),    32'(!mis));
        check({name, "_rv16"},  32'(bus.isrv16),         32'(rv16));
        check({name, "_instr"}, bus.rv32_instr,          instr);
    endtask

    initial begin
        bus.pc          = '0;
        bus.isram_cs    = 1'b0;
        bus.isram_adr   = '0;
        bus.isram_rdata = '0;
        bus.jb_ff       = 1'b0;

        apply(1, 0, 0, 0, JUNK, 0);
        lit("reset", 1, 0, 32'h0000_0013);
        apply(0, 0, 0, 0, JUNK, 0);
        lit("post_reset", 1, 0, 32'h0000_0013);
        apply(0, 0, 1, 0, JUNK, 0);
        lit("req_cycle", 1, 0, 32'h0000_0013);
        apply(0, 0, 0, 0, 64'h0000_4501_0051_0093, 0);
        lit("bypass_pc0", 0, 0, 32'h0051_0093);
        apply(0, 32'h2, 0, 0, JUNK, 0);
        lit("buf_pc2", 0, 1, 32'h0000_0051);
        apply(0, 32'h4, 0, 0, JUNK, 0);
        lit("buf_pc4", 0, 1, 32'h0000_4501);

        // straddle: line 0 refreshed with hw3=0093, line 1 supplies hw0=0051
        apply(0, 32'h6, 1, 0, JUNK, 0);
        apply(0, 32'h6, 0, 0, 64'h0093_1111_2222_3333, 0);
        lit("straddle_half", 1, 0, 32'h0000_0013);
        apply(0, 32'h6, 0, 0, JUNK, 0);
        lit("straddle_stall", 1, 0, 32'h0000_0013);
        apply(0, 32'h6, 1, 1, JUNK, 0);
        apply(0, 32'h6, 0, 0, 64'h1111_2222_3333_0051, 0);
        lit("straddle_byp", 0, 0, 32'h0051_0093);
        apply(0, 32'h6, 0, 0, JUNK, 0);
        lit("straddle_buf", 0, 0, 32'h0051_0093);

        // replacement: lines 0/1 held, pc on line 1, line 2 evicts line 0
        apply(0, 32'h8, 1, 2, JUNK, 0);
        lit("repl_pre", 0, 1, 32'h0000_0051);
        apply(0, 32'h8, 0, 0, 64'hAAAA_BBBB_CCCC_0017, 0);
        apply(0, 32'h8, 0, 0, JUNK, 0);
        lit("repl_keep1", 0, 1, 32'h0000_0051);
        apply(0, 32'h10, 0, 0, JUNK, 0);
        lit("repl_line2", 0, 0, 32'hCCCC_0017);
        apply(0, 32'h0, 0, 0, JUNK, 0);
        lit("repl_evict0", 1, 0, 32'h0000_0013);
        apply(0, 32'hE, 0, 0, JUNK, 0);
        lit("repl_pcE", 0, 1, 32'h0000_1111);

        // redirect with a response for line 0x40 in the flush cycle
        apply(0, 32'h8, 1, 0, JUNK, 0);
        apply(0, 32'h8, 0, 0, 64'h0000_4501_0051_0093, 0);
        apply(0, 32'h8, 1, 29'h40, JUNK, 0);
        apply(0, 32'h200, 0, 0, 64'h0000_0000_0001_0013, 1);
        lit("flush_bypass", 0, 0, 32'h0001_0013);
        apply(0, 32'h8, 0, 0, JUNK, 0);
        lit("flush_pc8", 1, 0, 32'h0000_0013);
        apply(0, 32'h0, 0, 0, JUNK, 0);
        lit("flush_pc0", 1, 0, 32'h0000_0013);
        apply(0, 32'h200, 0, 0, JUNK, 0);
        lit("flush_kept", 0, 0, 32'h0001_0013);
        apply(0, 32'h200, 0, 0, JUNK, 1);
        apply(0, 32'h200, 0, 0, JUNK, 0);
        lit("flush_empty", 1, 0, 32'h0000_0013);

        // wrap: hi halfword of pc FFFF_FFFE comes from tag 0
        apply(0, 32'hFFFF_FFFE, 1, 29'h1FFF_FFFF, JUNK, 0);
        apply(0, 32'hFFFF_FFFE, 0, 0, 64'h0197_0000_0000_0000, 0);
        lit("wrap_half", 1, 0, 32'h0000_0013);
        apply(0, 32'hFFFF_FFFE, 1, 0, JUNK, 0);
        apply(0, 32'hFFFF_FFFE, 0, 0, 64'h0000_0000_0000_1234, 0);
        lit("wrap_byp", 0, 0, 32'h1234_0197);
        apply(0, 32'hFFFF_FFFE, 0, 0, JUNK, 0);
        lit("wrap_buf", 0, 0, 32'h1234_0197);

        // async reset during a response drops it and clears the buffer
        apply(0, 32'hFFFF_FFFE, 1, 5, JUNK, 0);
        apply(1, 32'h28, 0, 0, 64'h0000_0000_0000_0001, 0);
        lit("rst_mid", 1, 0, 32'h0000_0013);
        apply(0, 32'hFFFF_FFFE, 0, 0, JUNK, 0);
        lit("rst_wrap_gone", 1, 0, 32'h0000_0013);
        apply(0, 32'h28, 0, 0, JUNK, 0);
        lit("rst_resp_drop", 1, 0, 32'h0000_0013);
        apply(0, 32'h28, 0, 0, JUNK, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
